// File: rtl/huff_pkg.sv
// Shared constants, FSM state type and a code-length mask helper for the Huffman decoder.
package huff_pkg;

  localparam int NSYM   = 16;
  localparam int IDX_W  = 4;
  localparam int MAXLEN = 8;
  localparam int LEN_W  = 4;
  localparam int SYM_W  = 8;
  localparam int WORD_W = 32;
  localparam int BUF_W  = 40;
  localparam int CNT_W  = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  // Mask with the low 'len' bits set; len values above MAXLEN saturate to all ones.
  function automatic logic [MAXLEN-1:0] len_mask(input logic [LEN_W-1:0] len);
    logic [MAXLEN-1:0] m;
    m = '0;
    for (int b = 0; b < MAXLEN; b++) m[b] = (b < int'(len));
    return m;
  endfunction

endpackage

// File: rtl/huff_code_match.sv
// Parallel compare of the buffer head against every table entry, lowest index wins.
module huff_code_match
  import huff_pkg::*;
(
  input  logic [NSYM*MAXLEN-1:0] tbl_codes,
  input  logic [NSYM*LEN_W-1:0]  tbl_lens,
  input  logic [NSYM*SYM_W-1:0]  tbl_syms,
  input  logic [MAXLEN-1:0]      head_bits,
  input  logic [CNT_W-1:0]       bit_count,
  output logic                   hit,
  output logic [IDX_W-1:0]       hit_idx,
  output logic [LEN_W-1:0]       hit_len,
  output logic [SYM_W-1:0]       hit_sym
);

  logic [NSYM-1:0] entry_hit;

  // An entry hits only if its length is legal, fully buffered, and its code bits agree.
  function automatic logic entry_matches(input logic [MAXLEN-1:0] code,
                                         input logic [LEN_W-1:0]  len,
                                         input logic [MAXLEN-1:0] bits,
                                         input logic [CNT_W-1:0]  count);
    logic [MAXLEN-1:0] mask;
    mask = len_mask(len);
    return (len != '0) && (len <= LEN_W'(MAXLEN)) && (CNT_W'(len) <= count) &&
           ((bits & mask) == (code & mask));
  endfunction

  // Per-entry hit vector.
  always_comb begin
    entry_hit = '0;
    for (int i = 0; i < NSYM; i++) begin
      entry_hit[i] = entry_matches(tbl_codes[i*MAXLEN +: MAXLEN], tbl_lens[i*LEN_W +: LEN_W],
                                   head_bits, bit_count);
    end
  end

  // Priority encoder: scan from the top so the lowest hitting index is the last assignment.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    hit_len = '0;
    hit_sym = '0;
    for (int i = NSYM - 1; i >= 0; i--) begin
      if (entry_hit[i]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
        hit_len = tbl_lens[i*LEN_W +: LEN_W];
        hit_sym = tbl_syms[i*SYM_W +: SYM_W];
      end
    end
  end

endmodule

// File: rtl/huffman_decoder.sv
// Huffman decoder: unpacks LSB-first 32-bit packed words into 8-bit symbols, one per clock.
// Word handshake: a word transfers on a clock edge where word_valid and word_ready are both 1;
// word_ready only depends on ce, state and bit_count, never on word_valid.
module huffman_decoder
  import huff_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              ce,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  input  logic              tbl_we,
  input  logic [IDX_W-1:0]  tbl_addr,
  input  logic [MAXLEN-1:0] tbl_code,
  input  logic [LEN_W-1:0]  tbl_len,
  input  logic [SYM_W-1:0]  tbl_sym,
  output logic [SYM_W-1:0]  symbol_out,
  output logic              symbol_valid,
  output logic              error,
  output logic [1:0]        dbg_state,
  output logic [IDX_W-1:0]  dbg_hit_idx
);

  logic [NSYM*MAXLEN-1:0] codes_q;
  logic [NSYM*LEN_W-1:0]  lens_q;
  logic [NSYM*SYM_W-1:0]  syms_q;

  state_t            state, state_nxt;
  logic [BUF_W-1:0]  bit_buf, buf_nxt;
  logic [CNT_W-1:0]  bit_count, cnt_nxt;
  logic [SYM_W-1:0]  sym_nxt;
  logic              valid_nxt, err_nxt;

  logic              m_hit;
  logic [IDX_W-1:0]  m_idx;
  logic [LEN_W-1:0]  m_len;
  logic [SYM_W-1:0]  m_sym;
  logic              accept;
  logic [CNT_W-1:0]  shift_len, ins_pos;

  assign word_ready  = ce && (state != ST_ERROR) && (bit_count <= CNT_W'(MAXLEN));
  assign accept      = word_valid && word_ready;
  assign dbg_state   = state;
  assign dbg_hit_idx = m_idx;

  huff_code_match u_match (
    .tbl_codes (codes_q),
    .tbl_lens  (lens_q),
    .tbl_syms  (syms_q),
    .head_bits (bit_buf[MAXLEN-1:0]),
    .bit_count (bit_count),
    .hit       (m_hit),
    .hit_idx   (m_idx),
    .hit_len   (m_len),
    .hit_sym   (m_sym)
  );

  // Code table registers; a write lands at the edge and is seen by matching next cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      codes_q <= '0;
      lens_q  <= '0;
      syms_q  <= '0;
    end else if (ce && tbl_we) begin
      codes_q[int'(tbl_addr)*MAXLEN +: MAXLEN] <= tbl_code;
      lens_q[int'(tbl_addr)*LEN_W +: LEN_W]    <= tbl_len;
      syms_q[int'(tbl_addr)*SYM_W +: SYM_W]    <= tbl_sym;
    end
  end

  // Next-state: consume the matched code and append an accepted word above the remaining bits.
  always_comb begin
    state_nxt = state;
    buf_nxt   = bit_buf;
    cnt_nxt   = bit_count;
    sym_nxt   = symbol_out;
    valid_nxt = 1'b0;
    err_nxt   = error;
    shift_len = m_hit ? CNT_W'(m_len) : '0;
    ins_pos   = bit_count - shift_len;
    if (state != ST_ERROR) begin
      if (!m_hit && (bit_count >= CNT_W'(MAXLEN))) begin
        // A full code window matches nothing: the stream cannot be decoded further.
        state_nxt = ST_ERROR;
        err_nxt   = 1'b1;
      end else begin
        buf_nxt = (bit_buf >> shift_len) | (accept ? (BUF_W'(word_in) << ins_pos) : '0);
        cnt_nxt = bit_count - shift_len + (accept ? CNT_W'(WORD_W) : '0);
        if (m_hit) begin
          sym_nxt   = m_sym;
          valid_nxt = 1'b1;
        end
        state_nxt = (cnt_nxt == '0) ? ST_IDLE : ST_RUN;
      end
    end
  end

  // State, buffer and output registers; ce low freezes everything but drops the pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      bit_buf      <= '0;
      bit_count    <= '0;
      symbol_out   <= '0;
      symbol_valid <= 1'b0;
      error        <= 1'b0;
    end else if (ce) begin
      state        <= state_nxt;
      bit_buf      <= buf_nxt;
      bit_count    <= cnt_nxt;
      symbol_out   <= sym_nxt;
      symbol_valid <= valid_nxt;
      error        <= err_nxt;
    end else begin
      symbol_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_huffman_decoder.sv
// Directed and randomized bench for huffman_decoder with a bit-list reference decoder.
module tb_huffman_decoder;
  import huff_pkg::*;

  logic        clock = 1'b0;
  logic        reset, ce, word_valid, tbl_we;
  logic [31:0] word_in;
  logic [3:0]  tbl_addr, tbl_len;
  logic [7:0]  tbl_code, tbl_sym;
  logic        word_ready, symbol_valid, error;
  logic [7:0]  symbol_out;
  logic [1:0]  dbg_state;
  logic [3:0]  dbg_hit_idx;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int first_cyc = 0;
  int last_cyc = 0;
  int acc_cyc = 0;
  int first_acc = 0;

  logic [7:0]  exp_q[$];
  logic [31:0] wq[$];
  bit          sbits[$];
  logic [7:0]  m_code[NSYM];
  int          m_len[NSYM];
  logic [7:0]  m_sym[NSYM];
  bit          m_err;

  typedef struct {
    logic [7:0] code;
    int         len;
  } pfx_t;

  huffman_decoder dut (
    .clock        (clock),
    .reset        (reset),
    .ce           (ce),
    .word_in      (word_in),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .tbl_we       (tbl_we),
    .tbl_addr     (tbl_addr),
    .tbl_code     (tbl_code),
    .tbl_len      (tbl_len),
    .tbl_sym      (tbl_sym),
    .symbol_out   (symbol_out),
    .symbol_valid (symbol_valid),
    .error        (error),
    .dbg_state    (dbg_state),
    .dbg_hit_idx  (dbg_hit_idx)
  );

  // Clock and cycle counter
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag, input int waited);
    checks++;
    errors++;
    $error("FAIL %s observed=timeout_after_%0d_cycles expected=completion", tag, waited);
  endtask

  // Scoreboard: every pulse must match the head of the expected queue
  always @(posedge clock) begin
    #1;
    if (symbol_valid !== 1'b0) begin
      pulse_cnt++;
      if (pulse_cnt == 1) first_cyc = cyc;
      last_cyc = cyc;
      check("sym_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("sym_value", symbol_out, exp_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < NSYM; i++) begin
      m_code[i] = 8'h00;
      m_len[i]  = 0;
      m_sym[i]  = 8'h00;
    end
    sbits.delete();
    wq.delete();
    exp_q.delete();
    pulse_cnt = 0;
    m_err = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ce = 1'b1;
    word_valid = 1'b0;
    tbl_we = 1'b0;
    step();
    reset = 1'b0;
    clear_model();
  endtask

  task automatic tbl_write(input int a, input logic [7:0] code, input int len, input logic [7:0] sym);
    tbl_we   = 1'b1;
    tbl_addr = a[3:0];
    tbl_code = code;
    tbl_len  = len[3:0];
    tbl_sym  = sym;
    step();
    tbl_we = 1'b0;
    m_code[a] = code;
    m_len[a]  = len;
    m_sym[a]  = sym;
  endtask

  task automatic load_t();
    tbl_write(0, 8'h00, 1, 8'h41);
    tbl_write(1, 8'h01, 2, 8'h42);
    tbl_write(2, 8'h03, 2, 8'h43);
  endtask

  task automatic add_word(input logic [31:0] w);
    wq.push_back(w);
    for (int b = 0; b < 32; b++) sbits.push_back(w[b]);
  endtask

  // Reference: greedy decode of the whole bit list, first table index whose code prefixes the rest.
  task automatic model_decode();
    int  pos;
    int  total;
    bit  found;
    bit  ok;
    pos = 0;
    total = sbits.size();
    m_err = 1'b0;
    forever begin
      found = 1'b0;
      for (int i = 0; i < NSYM && !found; i++) begin
        if (m_len[i] >= 1 && m_len[i] <= MAXLEN && m_len[i] <= total - pos) begin
          ok = 1'b1;
          for (int b = 0; b < m_len[i]; b++) if (sbits[pos+b] != m_code[i][b]) ok = 1'b0;
          if (ok) begin
            found = 1'b1;
            exp_q.push_back(m_sym[i]);
            pos += m_len[i];
          end
        end
      end
      if (!found) begin
        if (total - pos >= MAXLEN) m_err = 1'b1;
        break;
      end
    end
  endtask

  // Offer one word until accepted; gives up quietly once the decoder has flagged an error.
  task automatic send_word(input logic [31:0] w);
    int waited;
    waited = 0;
    word_in = w;
    word_valid = 1'b1;
    forever begin
      @(negedge clock);
      if (word_ready === 1'b1) begin
        step();
        acc_cyc = cyc;
        break;
      end
      if (error === 1'b1) break;
      waited++;
      if (waited > 300) begin
        timeout_fail("word_accept", waited);
        break;
      end
    end
  endtask

  task automatic send_all(input bit rand_gaps);
    for (int i = 0; i < wq.size(); i++) begin
      if (rand_gaps) begin
        word_valid = 1'b0;
        ce = ($urandom_range(0, 3) != 0);
        repeat ($urandom_range(0, 2)) step();
        ce = 1'b1;
      end
      send_word(wq[i]);
      if (i == 0) first_acc = acc_cyc;
    end
    word_valid = 1'b0;
    ce = 1'b1;
  endtask

  task automatic wait_pulses(input int n, input int limit);
    int k;
    k = 0;
    while (pulse_cnt < n && k < limit) begin
      @(posedge clock);
      #2;
      k++;
    end
    if (pulse_cnt < n) timeout_fail("wait_pulses", k);
  endtask

  task automatic wait_drain(input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) timeout_fail("drain", n);
    repeat (3) step();
  endtask

  // Random prefix-free table: codes are leaves of a randomly grown binary tree; some entries invalid.
  task automatic rand_table();
    pfx_t       fr[$];
    pfx_t       it;
    int         k;
    int         b;
    logic [7:0] hi;
    fr.push_back('{code: 8'h00, len: 0});
    for (int a = 0; a < NSYM; a++) begin
      if (fr.size() == 0 || $urandom_range(0, 5) == 0) begin
        tbl_write(a, 8'($urandom), ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(9, 15), 8'($urandom));
      end else begin
        k = $urandom_range(0, fr.size() - 1);
        it = fr[k];
        fr.delete(k);
        while (it.len == 0 || (it.len < MAXLEN && $urandom_range(0, 2) == 0)) begin
          b = $urandom_range(0, 1);
          fr.push_back('{code: it.code | (8'(1 - b) << it.len), len: it.len + 1});
          it.code = it.code | (8'(b) << it.len);
          it.len++;
        end
        hi = 8'hFF << it.len;
        tbl_write(a, it.code | (8'($urandom) & hi), it.len, 8'($urandom));
      end
    end
  endtask

  task automatic rand_stream(input int nwords);
    bit          bits[$];
    int          vidx[$];
    int          k;
    logic [31:0] w;
    for (int i = 0; i < NSYM; i++) if (m_len[i] >= 1 && m_len[i] <= MAXLEN) vidx.push_back(i);
    while (bits.size() < nwords * 32) begin
      if (vidx.size() == 0 || $urandom_range(0, 40) == 0) begin
        bits.push_back(1'($urandom_range(0, 1)));
      end else begin
        k = vidx[$urandom_range(0, vidx.size() - 1)];
        for (int b = 0; b < m_len[k]; b++) bits.push_back(m_code[k][b]);
      end
    end
    for (int i = 0; i < nwords; i++) begin
      for (int b = 0; b < 32; b++) w[b] = bits[i*32+b];
      add_word(w);
    end
  endtask

  // Directed sequence followed by randomized streams
  initial begin
    reset = 1'b1; ce = 1'b1; word_valid = 1'b0; word_in = '0;
    tbl_we = 1'b0; tbl_addr = '0; tbl_code = '0; tbl_len = '0; tbl_sym = '0;

    // Reset state
    do_reset();
    check("rst_symbol_out", symbol_out, 8'h00);
    check("rst_symbol_valid", symbol_valid, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_word_ready", word_ready, 1'b1);
    check("rst_state", dbg_state, ST_IDLE);

    // 1: two 0x42 then 28 0x41 on consecutive cycles
    load_t();
    add_word(32'h0000_0005);
    model_decode();
    send_all(1'b0);
    check("t1_first_idx", dbg_hit_idx, 4'd1);
    wait_drain(100);
    check("t1_count", pulse_cnt, 30);
    check("t1_latency", first_cyc, first_acc + 1);
    check("t1_no_gap", last_cyc - first_cyc, 29);
    check("t1_error", error, 1'b0);

    // 2: code straddling two words
    do_reset();
    load_t();
    add_word(32'h8000_0000);
    add_word(32'h0000_0000);
    model_decode();
    send_all(1'b0);
    wait_drain(200);
    check("t2_count", pulse_cnt, 63);
    check("t2_error", error, 1'b0);

    // 3: undecodable bits
    do_reset();
    tbl_write(0, 8'h00, 1, 8'h41);
    add_word(32'hFFFF_FFFF);
    model_decode();
    send_all(1'b0);
    step();
    check("t3_error", error, 1'b1);
    check("t3_word_ready", word_ready, 1'b0);
    check("t3_state", dbg_state, ST_ERROR);
    repeat (3) step();
    check("t3_no_symbols", pulse_cnt, 0);
    check("t3_model_err", error, m_err);
    do_reset();
    check("t3_rst_error", error, 1'b0);
    check("t3_rst_ready", word_ready, 1'b1);

    // 4: back-to-back words, no gap
    do_reset();
    load_t();
    repeat (4) add_word(32'h0);
    model_decode();
    send_all(1'b0);
    wait_drain(300);
    check("t4_count", pulse_cnt, 128);
    check("t4_no_gap", last_cyc - first_cyc, 127);
    check("t4_latency", first_cyc, first_acc + 1);

    // 5: ce low for 5 cycles after third symbol
    do_reset();
    load_t();
    add_word(32'h0000_0005);
    model_decode();
    send_all(1'b0);
    wait_pulses(3, 100);
    ce = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t5_frozen_valid", symbol_valid, 1'b0);
      check("t5_frozen_ready", word_ready, 1'b0);
    end
    check("t5_count_frozen", pulse_cnt, 3);
    ce = 1'b1;
    wait_drain(100);
    check("t5_total", pulse_cnt, 30);

    // 6: reset one cycle after tenth symbol
    do_reset();
    load_t();
    add_word(32'h0000_0005);
    model_decode();
    send_all(1'b0);
    wait_pulses(10, 100);
    reset = 1'b1;
    step();
    check("t6_valid_after_rst", symbol_valid, 1'b0);
    check("t6_ready_after_rst", word_ready, 1'b1);
    check("t6_state_after_rst", dbg_state, ST_IDLE);
    reset = 1'b0;
    clear_model();
    add_word(32'h0);
    model_decode();
    send_all(1'b0);
    repeat (3) step();
    check("t6_table_cleared", error, m_err);
    check("t6_no_symbols", pulse_cnt, 0);
    do_reset();
    load_t();
    add_word(32'h0000_0005);
    model_decode();
    send_all(1'b0);
    wait_drain(100);
    check("t6_resend_count", pulse_cnt, 30);
    check("t6_resend_error", error, 1'b0);

    // Randomized tables and streams with gaps and ce drops
    for (int t = 0; t < 10; t++) begin
      do_reset();
      rand_table();
      rand_stream($urandom_range(1, 5));
      model_decode();
      send_all(1'b1);
      wait_drain(600);
      check("rand_error", error, m_err);
      check("rand_leftover", exp_q.size(), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
